// File: rtl/xlr8_textram_ctrl.sv
// AVR register front end for a multi-plane text-mode display RAM.
// Provides address auto-increment, read prefetch, a hardware fill engine and a read-only display port.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | waiting for bus traffic; DATA accesses honoured
//   S_PF_ISSUE | port A read issued at addr
//   S_PF_LOAD  | prefetch registers loaded from port A read data
//   S_FILL     | every plane written with the fill value at fill_ctr
module xlr8_textram_ctrl #(
  parameter logic [7:0] ADDR_LO_ADDR = 8'd0,
  parameter logic [7:0] ADDR_HI_ADDR = 8'd0,
  parameter logic [7:0] DATA_BASE    = 8'd0,
  parameter logic [7:0] CTRL_ADDR    = 8'd0,
  parameter logic [7:0] FILL_ADDR    = 8'd0,
  parameter int         NPLANES      = 2,
  parameter int         ADDR_W       = 13,
  parameter int         DEPTH        = 2400
) (
  input  logic                   clk_pixel,
  input  logic                   rstn,
  input  logic                   clken,
  input  logic [7:0]             dbus_in,
  output logic [7:0]             dbus_out,
  output logic                   io_out_en,
  input  logic [7:0]             ramadr,
  input  logic                   ramre,
  input  logic                   ramwe,
  input  logic                   dm_sel,
  input  logic [ADDR_W-1:0]      disp_addr,
  input  logic                   disp_re,
  output logic [8*NPLANES-1:0]   disp_data,
  output logic                   disp_valid,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_PF_ISSUE, S_PF_LOAD, S_FILL} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   fill_ctr;
  logic [7:0]          fill_val;
  logic                autoinc;
  logic                err;
  logic [15:0]         addr_ext;
  logic [8*NPLANES-1:0] pf_flat;

  logic                hit_lo, hit_hi, hit_ctrl, hit_fill;
  logic [NPLANES-1:0]  hit_data;
  logic                wr_en, rd_act;
  logic                wr_lo, wr_hi, wr_ctrl, wr_fill;
  logic                idle, in_fill;
  logic                addr_wr, inc_ev, fill_go, fill_start, err_set;
  logic [NPLANES-1:0]  pf_wr;

  logic [ADDR_W-1:0]   ram_addr_a;
  logic [NPLANES-1:0]  ram_we_a;
  logic [7:0]          ram_wd_a;
  logic                pf_load;

  assign addr_ext = 16'(addr);

  always_comb begin
    hit_data = '0;
    for (int i = 0; i < NPLANES; i++)
      hit_data[i] = (ramadr == DATA_BASE + 8'(i));
  end

  assign hit_lo   = (ramadr == ADDR_LO_ADDR);
  assign hit_hi   = (ramadr == ADDR_HI_ADDR);
  assign hit_ctrl = (ramadr == CTRL_ADDR);
  assign hit_fill = (ramadr == FILL_ADDR);

  assign wr_en   = dm_sel & ramwe & clken;
  assign rd_act  = dm_sel & ramre & clken;
  assign wr_lo   = wr_en & hit_lo;
  assign wr_hi   = wr_en & hit_hi;
  assign wr_ctrl = wr_en & hit_ctrl;
  assign wr_fill = wr_en & hit_fill;

  assign idle    = (state == S_IDLE);
  assign in_fill = (state == S_FILL);

  assign addr_wr    = (wr_lo | wr_hi) & ~in_fill;
  assign inc_ev     = autoinc & idle & hit_data[NPLANES-1] & (wr_en | rd_act);
  assign fill_go    = wr_ctrl & dbus_in[1];
  assign fill_start = fill_go & ~in_fill;
  assign pf_wr      = (wr_en & idle) ? hit_data : '0;

  // DATA traffic is only honoured while idle; ADDR/FILL traffic only outside a fill
  assign err_set = (~idle & (|hit_data) & (wr_en | rd_act))
                 | (in_fill & (wr_lo | wr_hi | wr_fill | fill_go));

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fill_start)            state_nxt = S_FILL;
        else if (addr_wr | inc_ev) state_nxt = S_PF_ISSUE;
      end
      S_PF_ISSUE: begin
        if (fill_start)   state_nxt = S_FILL;
        else if (addr_wr) state_nxt = S_PF_ISSUE;
        else              state_nxt = S_PF_LOAD;
      end
      S_PF_LOAD: begin
        if (fill_start)   state_nxt = S_FILL;
        else if (addr_wr) state_nxt = S_PF_ISSUE;
        else              state_nxt = S_IDLE;
      end
      S_FILL: begin
        if (fill_ctr == ADDR_W'(DEPTH-1)) state_nxt = S_PF_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr_a = addr;
    ram_we_a   = pf_wr;
    ram_wd_a   = dbus_in;
    pf_load    = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE:    busy = 1'b0;
      S_PF_LOAD: pf_load = 1'b1;
      S_FILL: begin
        ram_addr_a = fill_ctr;
        ram_we_a   = '1;
        ram_wd_a   = fill_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      addr     <= '0;
      fill_ctr <= '0;
      fill_val <= '0;
      autoinc  <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (addr_wr & hit_lo)
        addr <= ADDR_W'({addr_ext[15:8], dbus_in});
      else if (addr_wr & hit_hi)
        addr <= ADDR_W'({dbus_in, addr_ext[7:0]});
      else if (inc_ev)
        addr <= (addr == ADDR_W'(DEPTH-1)) ? '0 : addr + ADDR_W'(1);

      if (fill_start)   fill_ctr <= '0;
      else if (in_fill) fill_ctr <= fill_ctr + ADDR_W'(1);

      if (wr_fill & ~in_fill) fill_val <= dbus_in;
      if (wr_ctrl)            autoinc  <= dbus_in[0];

      if (err_set)                   err <= 1'b1;
      else if (wr_ctrl & dbus_in[7]) err <= 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) disp_valid <= 1'b0;
    else       disp_valid <= disp_re;
  end

  for (genvar p = 0; p < NPLANES; p++) begin : g_plane
    logic [7:0] mem [2**ADDR_W];
    logic [7:0] q_a;
    logic [7:0] q_b;
    logic [7:0] pf_r;

    always_ff @(posedge clk_pixel) begin
      if (ram_we_a[p]) mem[ram_addr_a] <= ram_wd_a;
      q_a <= mem[ram_addr_a];
    end

    // display reads see pre-write contents on a same-address collision
    always_ff @(posedge clk_pixel or negedge rstn) begin
      if (!rstn)        q_b <= '0;
      else if (disp_re) q_b <= mem[disp_addr];
    end

    always_ff @(posedge clk_pixel or negedge rstn) begin
      if (!rstn)         pf_r <= '0;
      else if (pf_load)  pf_r <= q_a;
      else if (pf_wr[p]) pf_r <= dbus_in;
    end

    assign disp_data[8*p +: 8] = q_b;
    assign pf_flat[8*p +: 8]   = pf_r;
  end

  assign io_out_en = dm_sel & ramre & (hit_lo | hit_hi | hit_ctrl | hit_fill | (|hit_data));

  always_comb begin
    dbus_out = '0;
    if (hit_lo)        dbus_out = addr_ext[7:0];
    else if (hit_hi)   dbus_out = addr_ext[15:8];
    else if (hit_ctrl) dbus_out = {err, busy, 5'b0, autoinc};
    else if (hit_fill) dbus_out = fill_val;
    else begin
      for (int i = 0; i < NPLANES; i++)
        if (hit_data[i]) dbus_out = pf_flat[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_xlr8_textram_ctrl.sv
// Directed bench for xlr8_textram_ctrl: table-driven register vectors plus hand-written
// prefetch, wrap, fill, collision and reset sequences.
module tb_xlr8_textram_ctrl;

  localparam logic [7:0] A_LO   = 8'h20;
  localparam logic [7:0] A_HI   = 8'h21;
  localparam logic [7:0] A_D0   = 8'h22;
  localparam logic [7:0] A_D1   = 8'h23;
  localparam logic [7:0] A_CTRL = 8'h24;
  localparam logic [7:0] A_FILL = 8'h25;
  localparam int DEPTH = 2400;

  logic        clk_pixel = 1'b0;
  logic        rstn = 1'b0;
  logic        clken = 1'b0;
  logic [7:0]  dbus_in = '0;
  logic [7:0]  dbus_out;
  logic        io_out_en;
  logic [7:0]  ramadr = '0;
  logic        ramre = 1'b0;
  logic        ramwe = 1'b0;
  logic        dm_sel = 1'b0;
  logic [12:0] disp_addr = '0;
  logic        disp_re = 1'b0;
  logic [15:0] disp_data;
  logic        disp_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  xlr8_textram_ctrl #(
    .ADDR_LO_ADDR(A_LO), .ADDR_HI_ADDR(A_HI), .DATA_BASE(A_D0),
    .CTRL_ADDR(A_CTRL), .FILL_ADDR(A_FILL),
    .NPLANES(2), .ADDR_W(13), .DEPTH(DEPTH)
  ) dut (
    .clk_pixel(clk_pixel), .rstn(rstn), .clken(clken),
    .dbus_in(dbus_in), .dbus_out(dbus_out), .io_out_en(io_out_en),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
    .disp_addr(disp_addr), .disp_re(disp_re),
    .disp_data(disp_data), .disp_valid(disp_valid), .busy(busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         is_rd;
    logic [7:0] adr;
    logic [7:0] dat;
    logic [7:0] want;
    string      name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    @(negedge clk_pixel);
  endtask

  task automatic bus_wr_en(input logic [7:0] a, input logic [7:0] d, input logic en);
    ramadr = a; dbus_in = d; dm_sel = 1'b1; ramwe = 1'b1; clken = en;
    tick();
    ramwe = 1'b0; dm_sel = 1'b0; clken = 1'b1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    bus_wr_en(a, d, 1'b1);
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d, output logic oe);
    ramadr = a; dm_sel = 1'b1; ramre = 1'b1; clken = 1'b1;
    #1;
    d = dbus_out;
    oe = io_out_en;
    tick();
    ramre = 1'b0; dm_sel = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] want, input string name);
    logic [7:0] d;
    logic oe;
    bus_rd(a, d, oe);
    check(name, d, want);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  task automatic disp_rd(input logic [12:0] a, output logic [15:0] dd, output logic v);
    disp_addr = a; disp_re = 1'b1;
    tick();
    dd = disp_data;
    v = disp_valid;
    disp_re = 1'b0;
  endtask

  function automatic vec_t mk(input bit r, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] w, input string n);
    vec_t v;
    v.is_rd = r; v.adr = a; v.dat = d; v.want = w; v.name = n;
    return v;
  endfunction

  initial begin
    logic [7:0]  d;
    logic        oe;
    logic [15:0] dd;
    logic        v;
    int          n;
    int          bad;

    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h00, "rst_ctrl"));
    vq.push_back(mk(1, A_LO,   8'h00, 8'h00, "rst_addr_lo"));
    vq.push_back(mk(1, A_HI,   8'h00, 8'h00, "rst_addr_hi"));
    vq.push_back(mk(1, A_FILL, 8'h00, 8'h00, "rst_fill"));
    vq.push_back(mk(0, A_CTRL, 8'h01, 8'h00, ""));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h01, "autoinc_set"));
    vq.push_back(mk(0, A_HI,   8'hFF, 8'h00, ""));
    vq.push_back(mk(1, A_HI,   8'h00, 8'h1F, "addr_hi_masked"));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h41, "busy_pf_load"));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h01, "busy_clear"));
    vq.push_back(mk(0, A_HI,   8'h00, 8'h00, ""));
    vq.push_back(mk(0, A_LO,   8'h10, 8'h00, ""));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h41, "restart_issue"));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h41, "restart_load"));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h01, "restart_done"));
    vq.push_back(mk(0, A_D0,   8'h41, 8'h00, ""));
    vq.push_back(mk(1, A_D0,   8'h00, 8'h41, "pf_writethru"));
    vq.push_back(mk(1, A_LO,   8'h00, 8'h10, "plane0_no_inc"));
    vq.push_back(mk(0, A_D1,   8'h1F, 8'h00, ""));
    vq.push_back(mk(1, A_LO,   8'h00, 8'h11, "autoinc_lo"));
    vq.push_back(mk(1, A_HI,   8'h00, 8'h00, "autoinc_hi"));
    vq.push_back(mk(1, A_CTRL, 8'h00, 8'h01, "no_err"));

    repeat (3) @(negedge clk_pixel);
    check("rst_busy", busy, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 16'h0000);
    rstn = 1'b1;
    clken = 1'b1;
    tick();

    bus_wr_en(A_CTRL, 8'h01, 1'b0);
    bus_rd(8'h30, d, oe);
    check("unmapped_oe", oe, 0);

    foreach (vq[i]) begin
      if (vq[i].is_rd) begin
        bus_rd(vq[i].adr, d, oe);
        check(vq[i].name, d, vq[i].want);
        check({vq[i].name, "_oe"}, oe, 1);
      end else begin
        bus_wr(vq[i].adr, vq[i].dat);
      end
    end

    disp_rd(13'h0010, dd, v);
    check("disp_data_0010", dd, 16'h1F41);
    check("disp_valid_hi", v, 1);
    tick();
    check("disp_valid_lo", disp_valid, 0);
    check("disp_data_hold", disp_data, 16'h1F41);

    // wrap at DEPTH-1
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_LO, 8'h00);
    bus_wr(A_HI, 8'h00);
    wait_idle();
    bus_wr(A_D0, 8'hA5);
    bus_wr(A_D1, 8'h5A);
    bus_wr(A_LO, 8'h60);
    bus_wr(A_HI, 8'h09);
    wait_idle();
    bus_wr(A_D0, 8'h99);
    bus_wr(A_LO, 8'h5F);
    wait_idle();
    bus_wr(A_CTRL, 8'h01);
    bus_wr(A_D0, 8'h11);
    check("wrap_busy_before", busy, 0);
    bus_wr(A_D1, 8'h22);
    check("wrap_busy_c1", busy, 1);
    tick();
    check("wrap_busy_c2", busy, 1);
    tick();
    check("wrap_busy_c3", busy, 0);
    rd_chk(A_LO, 8'h00, "wrap_lo");
    rd_chk(A_HI, 8'h00, "wrap_hi");
    rd_chk(A_D0, 8'hA5, "wrap_pf_ram0");
    disp_rd(13'd2399, dd, v);
    check("disp_2399", dd, 16'h2211);
    disp_rd(13'd2400, dd, v);
    check("disp_2400_lo", dd[7:0], 8'h99);

    // fill engine with a mid-fill collision
    bus_wr(A_FILL, 8'h20);
    bus_wr(A_CTRL, 8'h03);
    check("fill_busy_start", busy, 1);
    n = 0;
    bus_wr(A_D0, 8'h77); n++;
    bus_rd(A_CTRL, d, oe); n++;
    check("fill_err_set", d, 8'hC1);
    bus_wr(A_CTRL, 8'h81); n++;
    bus_rd(A_CTRL, d, oe); n++;
    check("fill_err_clr", d, 8'h41);
    while (busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    check("fill_busy_cycles", n, DEPTH + 2);
    rd_chk(A_LO, 8'h00, "fill_addr_kept");
    rd_chk(A_D0, 8'h20, "fill_pf");
    bad = 0;
    disp_re = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      disp_addr = 13'(i);
      tick();
      if (disp_data !== 16'h2020 || disp_valid !== 1'b1) bad++;
    end
    disp_re = 1'b0;
    check("fill_cells_bad", bad, 0);
    disp_rd(13'd2400, dd, v);
    check("fill_past_depth", dd[7:0], 8'h99);

    // DATA read while prefetch pending
    bus_wr(A_CTRL, 8'h00);
    bus_wr(A_LO, 8'h00);
    bus_wr(A_HI, 8'h01);
    wait_idle();
    bus_wr(A_D0, 8'h3C);
    bus_wr(A_HI, 8'h00);
    wait_idle();
    bus_wr(A_LO, 8'h00);
    bus_wr(A_HI, 8'h01);
    rd_chk(A_D0, 8'h20, "stale_pf");
    rd_chk(A_CTRL, 8'hC0, "stale_err");
    rd_chk(A_D0, 8'h3C, "reread_pf");
    rd_chk(A_CTRL, 8'h80, "err_sticky");
    bus_wr(A_CTRL, 8'h80);
    rd_chk(A_CTRL, 8'h00, "err_w1c");

    // reset during fill
    bus_wr(A_FILL, 8'h55);
    bus_wr(A_CTRL, 8'h02);
    repeat (5) tick();
    bus_wr(A_CTRL, 8'h02);
    rd_chk(A_CTRL, 8'hC0, "go_in_fill_err");
    rstn = 1'b0;
    #1;
    check("midfill_rst_busy", busy, 0);
    check("midfill_rst_valid", disp_valid, 0);
    tick();
    rstn = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    rd_chk(A_CTRL, 8'h00, "post_rst_ctrl");
    rd_chk(A_FILL, 8'h00, "post_rst_fill");
    rd_chk(A_HI, 8'h00, "post_rst_hi");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
